// File: rtl/pfb_multichannel_mul_pipe_if.sv
// Valid/ready bundle for the PFB multichannel multiplier.
// master drives samples and accepts results; slave is the multiplier.
interface pfb_multichannel_mul_pipe_if #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 25,
  parameter int CH_WIDTH   = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic [CH_WIDTH-1:0]   in_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic [CH_WIDTH-1:0]   out_ch;
  logic                  out_ovf;
  logic [15:0]           sat_cnt;
  logic                  sat_clr;

  modport master (
    output in_valid, din0, din1, in_ch,
    output out_ready, sat_clr,
    input  in_ready, out_valid, dout,
    input  out_ch, out_ovf, sat_cnt
  );

  modport slave (
    input  in_valid, din0, din1, in_ch,
    input  out_ready, sat_clr,
    output in_ready, out_valid, dout,
    output out_ch, out_ovf, sat_cnt
  );
endinterface

// File: rtl/pfb_multichannel_mul_pipe.sv
// Pipelined multiply / shift / saturate with channel tag and overflow count.
// Optional round-half-up before the shift: define PFB_MUL_ROUND_EN.
module pfb_multichannel_mul_pipe #(
  parameter int DIN0_WIDTH  = 14,
  parameter int DIN1_WIDTH  = 12,
  parameter int DOUT_WIDTH  = 25,
  parameter int NUM_STAGE   = 3,
  parameter int SIGNED_MODE = 0,
  parameter int SHIFT       = 0,
  parameter int CH_WIDTH    = 5
) (
  input logic ap_clk,
  input logic ap_rst_n,
  pfb_multichannel_mul_pipe_if.slave bus
);

  localparam int P  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int W  = (P + 2 > DOUT_WIDTH + 1) ? P + 2 : DOUT_WIDTH + 1;
  localparam int NP = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
`ifdef PFB_MUL_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  localparam logic signed [W-1:0] ONE  = 1;
  localparam logic signed [W-1:0] RND  =
    (RND_EN && SHIFT > 0) ? (ONE << RS) : '0;
  localparam logic signed [W-1:0] UMAX = (ONE << DOUT_WIDTH) - ONE;
  localparam logic signed [W-1:0] SMAX = (ONE << (DOUT_WIDTH - 1)) - ONE;
  localparam logic signed [W-1:0] SMIN = -SMAX - ONE;
  localparam logic signed [W-1:0] HI   = (SIGNED_MODE != 0) ? SMAX : UMAX;
  localparam logic signed [W-1:0] LO   = (SIGNED_MODE != 0) ? SMIN : '0;

  typedef struct packed {
    logic                v;
    logic [CH_WIDTH-1:0] ch;
    logic [P-1:0]        p;
  } mul_t;

  logic adv;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  logic         sa;
  logic         sb;
  logic [P-1:0] a;
  logic [P-1:0] b;
  mul_t         mul_in;
  mul_t         pre;

  always_comb begin
    sa = (SIGNED_MODE != 0) && bus.din0[DIN0_WIDTH-1];
    sb = (SIGNED_MODE != 0) && bus.din1[DIN1_WIDTH-1];
    a = {{DIN1_WIDTH{sa}}, bus.din0};
    b = {{DIN0_WIDTH{sb}}, bus.din1};
    mul_in.v  = bus.in_valid;
    mul_in.ch = bus.in_ch;
    mul_in.p  = a * b;
  end

  if (NUM_STAGE > 1) begin : g_pipe
    mul_t mul_q [NP];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NP; i++) mul_q[i] <= '0;
      end else if (adv) begin
        mul_q[0] <= mul_in;
        for (int i = 1; i < NP; i++) mul_q[i] <= mul_q[i-1];
      end
    end

    assign pre = mul_q[NP-1];
  end else begin : g_flat
    assign pre = mul_in;
  end

  logic                  sg;
  logic signed [W-1:0]   ext;
  logic signed [W-1:0]   sum;
  logic signed [W-1:0]   sh;
  logic                  hi;
  logic                  lo;
  logic [DOUT_WIDTH-1:0] res;

  // Rounding happens before the shift; clamp compares the shifted value.
  always_comb begin
    sg  = (SIGNED_MODE != 0) && pre.p[P-1];
    ext = {{(W - P){sg}}, pre.p};
    sum = ext + RND;
    sh  = sum >>> SHIFT;
    hi  = sh > HI;
    lo  = sh < LO;
    res = sh[DOUT_WIDTH-1:0];
    if (hi) res = HI[DOUT_WIDTH-1:0];
    if (lo) res = LO[DOUT_WIDTH-1:0];
  end

  logic                  vld_q;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic [CH_WIDTH-1:0]   ch_q;
  logic                  ovf_q;
  logic [15:0]           cnt_q;
  logic                  inc;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
      ch_q   <= '0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      vld_q  <= pre.v;
      dout_q <= res;
      ch_q   <= pre.ch;
      ovf_q  <= hi || lo;
    end
  end

  assign inc = vld_q && bus.out_ready && ovf_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
    end else if (bus.sat_clr) begin
      cnt_q <= inc ? 16'd1 : 16'd0;
    end else if (inc && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.dout      = dout_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.sat_cnt   = cnt_q;

endmodule
